axil_native_bridge: RTL
=======================

# axil_native_bridge

Parametrised AXI4-Lite slave to native register-bus bridge; successor of the single-FSM bridge. Independent write and read engines run concurrently, AW and W are accepted in any order, byte strobes pass through, and the native side acknowledges with error reporting. A per-access timeout guarantees an AXI response even when the native slave never answers. Sits between the AXI4-Lite interconnect and register files/peripherals.

## Interface
- DATA_WIDTH, 32, data width; multiple of 8
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 16, max cycles a native access waits for ack; 0 disables timeout
- AXI_ACLK  in  1  clock
- AXI_ARESETN  in  1  reset; asynchronous, active-low
- AXI_AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1  write address; AWPROT ignored
- AXI_AWREADY  out  1  write address ready
- AXI_WDATA/WSTRB/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- AXI_WREADY  out  1  write data ready
- AXI_BRESP/BVALID  out  2/1, AXI_BREADY  in  1  write response
- AXI_ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1, AXI_ARREADY  out  1  read address; ARPROT ignored
- AXI_RDATA/RRESP/RVALID  out  DATA_WIDTH/2/1, AXI_RREADY  in  1  read data
- WEN  out  1  native write request, held until WACK or timeout
- WADDR/WDATA/WSTRB  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  native write payload, stable while WEN
- WACK/WERR  in  1/1  native write ack; WERR sampled with WACK
- REN  out  1  native read request, held until RVALID or timeout
- RADDR  out  ADDR_WIDTH  native read address, stable while REN
- RDATA/RVALID/RERR  in  DATA_WIDTH/1/1  native read data, valid, error (sampled with RVALID)

## Operation
- Write FSM: W_COLLECT -> W_NATIVE -> W_RESP -> W_COLLECT.
  - W_COLLECT: AWREADY = !aw_held, WREADY = !w_held (register-derived, no combinational path from VALID). Each handshake latches its payload and sets its flag; both may occur same cycle or in either order. When both flags set: go W_NATIVE, WEN=1.
  - W_NATIVE: WEN high. WACK=1 -> BRESP = WERR ? 2'b10 : 2'b00, BVALID=1, go W_RESP. Timeout -> BRESP=2'b10, WEN drops, go W_RESP.
  - W_RESP: BVALID held until BREADY; then clear flags, W_COLLECT.
- Read FSM: R_IDLE -> R_NATIVE -> R_RESP -> R_IDLE.
  - R_IDLE: ARREADY=1; handshake latches RADDR, REN=1, go R_NATIVE.
  - R_NATIVE: RVALID=1 -> AXI_RDATA=RDATA, RRESP = RERR ? 2'b10 : 2'b00, go R_RESP. Timeout -> AXI_RDATA=0, RRESP=2'b10.
  - R_RESP: AXI_RVALID held, RDATA/RRESP stable, until RREADY; then R_IDLE.
- Timeout counters (one per engine) clear on entering *_NATIVE, increment each cycle without ack; timeout fires when count reaches TIMEOUT_CYCLES-1 without ack (access lasts exactly TIMEOUT_CYCLES cycles). TIMEOUT_CYCLES=0: wait forever.
- Engines are fully independent; WEN and REN may be high the same cycle; no read/write ordering guaranteed.
- Ack/RVALID outside *_NATIVE ignored. Only OKAY (00) and SLVERR (10) ever produced.

## Timing
- Reset (async assert, sync release inside): AWREADY=0 while reset, WREADY=0, ARREADY=0, BVALID=0, BRESP=00, RVALID=0, RRESP=00, AXI_RDATA=0, WEN=0, REN=0, WADDR/WDATA/WSTRB/RADDR=0; FSMs to W_COLLECT/R_IDLE, flags and counters cleared. First cycle after release: AWREADY=WREADY=ARREADY=1.
- Write latency: AW+W handshake cycle N -> WEN high N+1; WACK at N+1 -> BVALID N+2. Split AW/W: WEN one cycle after the later handshake.
- Read latency: AR handshake N -> REN N+1; RVALID at N+1 -> AXI_RVALID N+2.
- Back-to-back: next AW/W/AR accepted the cycle after BREADY/RREADY handshake; throughput one write per 3 cycles, one read per 3 cycles minimum.
- Reset mid-operation: in-flight accesses dropped, no response issued, WEN/REN fall immediately.

## Test plan
- Reset: assert AXI_ARESETN=0 mid-read with REN high -> REN, RVALID, ARREADY drop asynchronously; after release AWREADY=WREADY=ARREADY=1, all others 0.
- Write W-before-AW: WDATA=0xDEADBEEF, WSTRB=4'b0101 at cycle 0, AWADDR=0x40 at cycle 3 -> WEN at cycle 4 with WADDR=0x40, WDATA=0xDEADBEEF, WSTRB=0101; WACK at 4 -> BVALID=1, BRESP=00 at 5.
- Read error: ARADDR=0x10, native RVALID=1, RERR=1, RDATA=0x1234 after 2 cycles -> AXI_RDATA=0x1234, RRESP=10; RREADY held low 5 cycles -> RVALID/RDATA stable.
- Timeout: TIMEOUT_CYCLES=16, write with WACK never asserted -> WEN high exactly 16 cycles, then BRESP=10, BVALID=1; read likewise -> RRESP=10, AXI_RDATA=0.
- Concurrency: AW+W and AR in same cycle -> WEN and REN both high next cycle; both responses returned independently, correct data/resp.
- Back-to-back: 100 random writes/reads with random VALID/READY stalls against a register-file model -> every read returns last written strobe-merged value, no dropped or duplicated WEN/REN pulses.

Source files
------------

// File: rtl/axil_native_bridge.sv
// axil_native_bridge
//   AXI4-Lite slave to native register-bus bridge. The write engine and the
//   read engine are independent and can run at the same time. AW and W can
//   arrive in either order, and byte strobes pass straight through. Each
//   native access carries a timeout, so an AXI response is always issued,
//   even when the native slave never answers.
//
// Ports
//   AXI_ACLK, AXI_ARESETN              clock, async active-low reset
//   AXI_AW*/W*/B*                      AXI4-Lite write address/data/response
//   AXI_AR*/R*                         AXI4-Lite read address/data
//   WEN, WADDR, WDATA, WSTRB           native write request + payload
//   WACK, WERR                         native write acknowledge / error
//   REN, RADDR                         native read request + address
//   RDATA, RVALID, RERR                native read data / valid / error
module axil_native_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [2:0]              AXI_AWPROT,
    input  logic                    AXI_AWVALID,
    output logic                    AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                    AXI_WVALID,
    output logic                    AXI_WREADY,
    output logic [1:0]              AXI_BRESP,
    output logic                    AXI_BVALID,
    input  logic                    AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic [2:0]              AXI_ARPROT,
    input  logic                    AXI_ARVALID,
    output logic                    AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   AXI_RDATA,
    output logic [1:0]              AXI_RRESP,
    output logic                    AXI_RVALID,
    input  logic                    AXI_RREADY,
    output logic                    WEN,
    output logic [ADDR_WIDTH-1:0]   WADDR,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WACK,
    input  logic                    WERR,
    output logic                    REN,
    output logic [ADDR_WIDTH-1:0]   RADDR,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    RVALID,
    input  logic                    RERR
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {W_COLLECT, W_NATIVE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_NATIVE, R_RESP} rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;
    logic    alive;
    logic    aw_held, w_held;
    logic    [CW-1:0] w_cnt, r_cnt;
    logic    aw_hs, w_hs, ar_hs, w_to, r_to;

    logic unused_prot;
    assign unused_prot = ^{AXI_AWPROT, AXI_ARPROT};

    // The ready outputs stay low until one clock edge after reset release.
    // This keeps the release synchronous, even though all of the state
    // below is cleared asynchronously.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
        if (!AXI_ARESETN) alive <= 1'b0;
        else              alive <= 1'b1;

    // Every ready and valid output is decoded from registers only, so there
    // is no combinational path from a VALID input to a READY output.
    assign AXI_AWREADY = alive && (w_state == W_COLLECT) && !aw_held;
    assign AXI_WREADY  = alive && (w_state == W_COLLECT) && !w_held;
    assign AXI_ARREADY = alive && (r_state == R_IDLE);
    assign WEN         = (w_state == W_NATIVE);
    assign REN         = (r_state == R_NATIVE);
    assign AXI_BVALID  = (w_state == W_RESP);
    assign AXI_RVALID  = (r_state == R_RESP);

    assign aw_hs = AXI_AWVALID && AXI_AWREADY;
    assign w_hs  = AXI_WVALID && AXI_WREADY;
    assign ar_hs = AXI_ARVALID && AXI_ARREADY;
    // The timeout fires on the last allowed cycle, so a native access that
    // never gets an ack lasts exactly TIMEOUT_CYCLES cycles.
    assign w_to  = TO_EN && (w_cnt == TO_LAST);
    assign r_to  = TO_EN && (r_cnt == TO_LAST);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
        if (!AXI_ARESETN) begin
            w_state <= W_COLLECT;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_COLLECT: if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_NATIVE;
            W_NATIVE:  if (WACK || w_to) w_next = W_RESP;
            W_RESP:    if (AXI_BREADY) w_next = W_COLLECT;
            default:   w_next = W_COLLECT;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:   if (ar_hs) r_next = R_NATIVE;
            R_NATIVE: if (RVALID || r_to) r_next = R_RESP;
            R_RESP:   if (AXI_RREADY) r_next = R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    // Write datapath: address and data are captured separately, then
    // released together to the native side.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
        if (!AXI_ARESETN) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            WADDR     <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            AXI_BRESP <= 2'b00;
            w_cnt     <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                WADDR   <= AXI_AWADDR;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                WDATA  <= AXI_WDATA;
                WSTRB  <= AXI_WSTRB;
            end
            if (w_state == W_NATIVE) begin
                w_cnt <= w_cnt + 1'b1;
                if (WACK)      AXI_BRESP <= WERR ? 2'b10 : 2'b00;
                else if (w_to) AXI_BRESP <= 2'b10;
            end else begin
                w_cnt <= '0;
            end
            if ((w_state == W_RESP) && AXI_BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
        if (!AXI_ARESETN) begin
            RADDR     <= '0;
            AXI_RDATA <= '0;
            AXI_RRESP <= 2'b00;
            r_cnt     <= '0;
        end else begin
            if (ar_hs) RADDR <= AXI_ARADDR;
            if (r_state == R_NATIVE) begin
                r_cnt <= r_cnt + 1'b1;
                if (RVALID) begin
                    AXI_RDATA <= RDATA;
                    AXI_RRESP <= RERR ? 2'b10 : 2'b00;
                end else if (r_to) begin
                    AXI_RDATA <= '0;
                    AXI_RRESP <= 2'b10;
                end
            end else begin
                r_cnt <= '0;
            end
        end

endmodule
